// File: rtl/branch_tracker_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// branch_tracker_pkg : tracker FSM state encoding and default queue depth
// Revision: 1.0
// ---------------------------------------------------------------------------
package branch_tracker_pkg;

  localparam int DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CAPT = 2'd2,
    UPD  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/branch_tracker_pred_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pred_fifo : 1-bit wide queue of outstanding predictions with flush
// Revision: 1.0
// ---------------------------------------------------------------------------
module pred_fifo
  import branch_tracker_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0] mem_q,   mem_d;
  logic [AW-1:0]    head_q,  head_d;
  logic [AW-1:0]    tail_q,  tail_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = push_data;
        tail_d        = tail_q + AW'(1);
      end
      if (pop) begin
        head_d = head_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_data = mem_q[head_q];
  assign count     = count_q;

endmodule
`default_nettype wire

// File: rtl/branch_tracker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// branch_tracker : requests predictions for fetched branches, queues them and
//                  trains the predictor / flags mispredicts on resolution
// Revision: 1.0
// ---------------------------------------------------------------------------
module branch_tracker
  import branch_tracker_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     br_valid,
  output logic                     br_ready,
  output logic                     fetch_pred_valid,
  output logic                     fetch_pred,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  output logic                     resolve_ready,
  output logic                     mispredict,
  output logic                     pred_request,
  output logic                     pred_result,
  output logic                     pred_taken,
  input  logic                     pred_in,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t state_q, state_d;
  logic   taken_q, taken_d;
  logic   stored_pred_q, stored_pred_d;
  logic   fifo_head;
  logic   in_idle;
  logic   in_upd;

  assign in_idle = (state_q == IDLE);
  assign in_upd  = (state_q == UPD);

  // Ready outputs are held low while reset is asserted so the port is fully quiet.
  assign resolve_ready    = !reset && in_idle && (count != '0);
  assign br_ready         = !reset && in_idle && (count != CW'(DEPTH)) &&
                            !(resolve_valid && resolve_ready);
  assign pred_request     = (state_q == REQ);
  assign pred_result      = in_upd;
  assign pred_taken       = in_upd && taken_q;
  assign mispredict       = in_upd && (stored_pred_q != taken_q);
  assign fetch_pred_valid = (state_q == CAPT);
  assign fetch_pred       = (state_q == CAPT) && pred_in;

  always_comb begin
    state_d       = state_q;
    taken_d       = taken_q;
    stored_pred_d = stored_pred_q;
    case (state_q)
      IDLE: begin
        if (resolve_valid && resolve_ready) begin
          state_d       = UPD;
          taken_d       = resolve_taken;
          stored_pred_d = fifo_head;
        end else if (br_valid && br_ready) begin
          state_d = REQ;
        end
      end
      REQ:     state_d = CAPT;
      CAPT:    state_d = IDLE;
      UPD:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      taken_q       <= 1'b0;
      stored_pred_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      taken_q       <= taken_d;
      stored_pred_q <= stored_pred_d;
    end
  end

  // A mispredict squashes every younger prediction, so flush wins over the pop.
  pred_fifo #(
    .DEPTH (DEPTH)
  ) u_pred_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (state_q == CAPT),
    .push_data (pred_in),
    .pop       (in_upd),
    .flush     (mispredict),
    .head_data (fifo_head),
    .count     (count)
  );

endmodule
`default_nettype wire

// File: tb/tb_branch_tracker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_branch_tracker : directed stimulus with queue-based scoreboard
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_branch_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic       br_valid;
  logic       br_ready;
  logic       fetch_pred_valid;
  logic       fetch_pred;
  logic       resolve_valid;
  logic       resolve_taken;
  logic       resolve_ready;
  logic       mispredict;
  logic       pred_request;
  logic       pred_result;
  logic       pred_taken;
  logic       pred_in;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  logic       exp_pred_q[$];
  logic [1:0] exp_upd_q[$];

  logic [1:0] ctr;

  always #5 clk = ~clk;

  branch_tracker #(.DEPTH(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .br_valid         (br_valid),
    .br_ready         (br_ready),
    .fetch_pred_valid (fetch_pred_valid),
    .fetch_pred       (fetch_pred),
    .resolve_valid    (resolve_valid),
    .resolve_taken    (resolve_taken),
    .resolve_ready    (resolve_ready),
    .mispredict       (mispredict),
    .pred_request     (pred_request),
    .pred_result      (pred_result),
    .pred_taken       (pred_taken),
    .pred_in          (pred_in),
    .count            (count)
  );

  // 2-bit saturating-counter predictor with registered output
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ctr     <= 2'b00;
      pred_in <= 1'b0;
    end else begin
      if (pred_request) pred_in <= ctr[1];
      if (pred_result) begin
        if (pred_taken) ctr <= (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        else            ctr <= (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a prediction or an update
  always @(negedge clk) begin
    if (!reset) begin
      if (fetch_pred_valid) begin
        if (exp_pred_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_fetch_pred_valid: got 1 expected 0 at %0t", $time);
        end else begin
          chk("fetch_pred", fetch_pred, exp_pred_q.pop_front());
        end
      end
      if (pred_result) begin
        if (exp_upd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pred_result: got 1 expected 0 at %0t", $time);
        end else begin
          chk("upd_taken_mispredict", {pred_taken, mispredict}, exp_upd_q.pop_front());
        end
      end else if (mispredict) begin
        checks++; errors++;
        $display("FAIL mispredict_outside_upd: got 1 expected 0 at %0t", $time);
      end
      if (pred_request && pred_result) begin
        checks++; errors++;
        $display("FAIL req_and_result_together: got 1 expected 0 at %0t", $time);
      end
    end
  end

  task automatic send_branch(input logic exp_pred);
    int n;
    exp_pred_q.push_back(exp_pred);
    br_valid = 1'b1;
    #1;
    n = 0;
    while (!br_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("br_handshake", br_ready, 1);
    @(posedge clk);
    @(negedge clk);
    br_valid = 1'b0;
    chk("req_pred_request", pred_request, 1);
    chk("req_no_fetch_valid", fetch_pred_valid, 0);
    @(negedge clk);
    chk("capt_fetch_valid", fetch_pred_valid, 1);
    @(negedge clk);
  endtask

  task automatic resolve(input logic taken, input logic exp_misp);
    int n;
    exp_upd_q.push_back({taken, exp_misp});
    resolve_valid = 1'b1;
    resolve_taken = taken;
    #1;
    n = 0;
    while (!resolve_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("resolve_handshake", resolve_ready, 1);
    @(posedge clk);
    @(negedge clk);
    resolve_valid = 1'b0;
    resolve_taken = 1'b0;
    chk("upd_pred_result", pred_result, 1);
    chk("upd_no_request", pred_request, 0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    br_valid      = 1'b0;
    resolve_valid = 1'b0;
    resolve_taken = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_br_ready", br_ready, 0);
    chk("rst_resolve_ready", resolve_ready, 0);
    chk("rst_count", count, 0);
    chk("rst_pred_request", pred_request, 0);
    chk("rst_fetch_valid", fetch_pred_valid, 0);
    reset = 1'b0;
    #1;
    chk("idle_br_ready", br_ready, 1);
    chk("idle_resolve_ready_empty", resolve_ready, 0);

    // Resolve against an empty queue is ignored
    resolve_valid = 1'b1;
    resolve_taken = 1'b1;
    #1;
    chk("empty_resolve_ready", resolve_ready, 0);
    repeat (2) @(negedge clk);
    resolve_valid = 1'b0;
    resolve_taken = 1'b0;
    chk("empty_count", count, 0);

    // Single branch, then fill to DEPTH
    send_branch(1'b0);
    chk("single_count", count, 1);
    for (int i = 0; i < 3; i++) send_branch(1'b0);
    chk("full_count", count, 4);
    br_valid = 1'b1;
    #1;
    chk("full_br_ready", br_ready, 0);
    repeat (3) @(negedge clk);
    chk("full_held_count", count, 4);
    chk("full_held_br_ready", br_ready, 0);
    br_valid = 1'b0;
    resolve(1'b0, 1'b0);
    chk("after_resolve_count", count, 3);
    send_branch(1'b0);
    chk("refill_count", count, 4);

    // Mispredict flushes all younger entries
    resolve(1'b1, 1'b1);
    chk("mispredict_flush_count", count, 0);

    // Simultaneous branch and resolve: resolve wins, branch follows
    send_branch(1'b0);
    send_branch(1'b0);
    chk("pair_count", count, 2);
    exp_upd_q.push_back(2'b00);
    exp_pred_q.push_back(1'b0);
    br_valid      = 1'b1;
    resolve_valid = 1'b1;
    resolve_taken = 1'b0;
    #1;
    chk("sim_br_ready_low", br_ready, 0);
    chk("sim_resolve_ready", resolve_ready, 1);
    @(posedge clk);
    @(negedge clk);
    resolve_valid = 1'b0;
    chk("sim_upd", pred_result, 1);
    chk("sim_br_ready_upd", br_ready, 0);
    @(negedge clk);
    chk("sim_idle_br_ready", br_ready, 1);
    chk("sim_count_after_resolve", count, 1);
    @(negedge clk);
    br_valid = 1'b0;
    chk("sim_branch_req", pred_request, 1);
    repeat (2) @(negedge clk);
    chk("sim_count_final", count, 2);

    resolve(1'b0, 1'b0);
    resolve(1'b0, 1'b0);
    chk("drain_count", count, 0);

    // Pointer wrap through repeated pairs
    for (int i = 0; i < 6; i++) begin
      send_branch(1'b0);
      chk("wrap_count_one", count, 1);
      resolve(1'b0, 1'b0);
      chk("wrap_count_zero", count, 0);
    end

    // Reset asserted while in CAPT drops the in-flight branch
    send_branch(1'b0);
    chk("pre_reset_count", count, 1);
    br_valid = 1'b1;
    #1;
    chk("pre_reset_br_ready", br_ready, 1);
    @(posedge clk);
    @(negedge clk);
    br_valid = 1'b0;
    chk("pre_reset_req", pred_request, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("capt_reset_fetch_valid", fetch_pred_valid, 0);
    chk("capt_reset_count", count, 0);
    chk("capt_reset_br_ready", br_ready, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_reset_count", count, 0);

    // First edge after reset acts as IDLE
    send_branch(1'b0);
    chk("post_reset_branch_count", count, 1);
    resolve(1'b0, 1'b0);
    chk("post_reset_resolve_count", count, 0);

    repeat (2) @(negedge clk);
    chk("pred_queue_empty", exp_pred_q.size(), 0);
    chk("upd_queue_empty", exp_upd_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
